// File: rtl/vending_machine.sv
// vending_machine: single-product ticket vending controller with credit accumulator.
// Optional macro VM_CHANGE_EN adds the registered overpay output `change`.
module vending_machine #(
    parameter int NICKEL_VAL = 5,
    parameter int DIME_VAL   = 10,
    parameter int PRICE      = 15,
    parameter int CW         = 5
) (
    input  logic [1:0]    coin,
    input  logic          rst,
    output logic          ticket,
    input  logic          clk,
    output logic [CW-1:0] credit,
    output logic          reject
`ifdef VM_CHANGE_EN
    ,
    output logic [CW-1:0] change
`endif
);

    localparam logic [CW:0]   LP_NICKEL   = (CW+1)'(NICKEL_VAL);
    localparam logic [CW:0]   LP_DIME     = (CW+1)'(DIME_VAL);
    localparam logic [CW:0]   LP_PRICE    = (CW+1)'(PRICE);
    localparam logic [CW-1:0] LP_PRICE_CW = CW'(PRICE);

    logic [CW-1:0] r_credit;
    logic          r_ticket;
    logic          r_reject;

    logic [CW:0]   w_val;
    logic [CW:0]   w_sum;
    logic [CW-1:0] w_credit_nxt;
    logic          w_ticket_nxt;
    logic          w_reject_nxt;

    always_comb begin
        unique case (coin)
            2'b01:   w_val = LP_NICKEL;
            2'b10:   w_val = LP_DIME;
            default: w_val = '0;
        endcase
    end

    always_comb begin
        w_sum        = {1'b0, r_credit} + w_val;
        w_credit_nxt = r_credit;
        w_ticket_nxt = 1'b0;
        w_reject_nxt = (coin == 2'b11);
        // An out-of-range credit is scrubbed without selling a ticket
        if ({1'b0, r_credit} >= LP_PRICE) begin
            w_credit_nxt = '0;
        end else if (w_val != '0) begin
            if (w_sum >= LP_PRICE) begin
                w_ticket_nxt = 1'b1;
                w_credit_nxt = '0;
            end else begin
                w_credit_nxt = w_sum[CW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit <= '0;
            r_ticket <= 1'b0;
            r_reject <= 1'b0;
        end else begin
            r_credit <= w_credit_nxt;
            r_ticket <= w_ticket_nxt;
            r_reject <= w_reject_nxt;
        end
    end

    assign credit = r_credit;
    assign ticket = r_ticket;
    assign reject = r_reject;

`ifdef VM_CHANGE_EN
    logic [CW-1:0] r_change;
    logic [CW-1:0] w_change_nxt;

    // Overpay is below 2^CW, so modulo-CW subtraction is exact
    assign w_change_nxt = w_ticket_nxt ? (w_sum[CW-1:0] - LP_PRICE_CW) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_change <= '0;
        end else begin
            r_change <= w_change_nxt;
        end
    end

    assign change = r_change;
`endif

endmodule

// File: tb/tb_vending_machine.sv
// tb_vending_machine: directed plus random coin stimulus against an integer credit model.
// Checks change only when built with VM_CHANGE_EN.
module tb_vending_machine;

    localparam int NICKEL = 5;
    localparam int DIME   = 10;
    localparam int PRICE  = 15;
    localparam int CW     = 5;

    logic          clk;
    logic          rst;
    logic [1:0]    coin;
    logic          ticket;
    logic          reject;
    logic [CW-1:0] credit;
`ifdef VM_CHANGE_EN
    logic [CW-1:0] change;
`endif

    int errors = 0;
    int checks = 0;
    int m_credit = 0;
    int m_ticket = 0;
    int m_reject = 0;
    int m_change = 0;
    int n_tickets = 0;

    vending_machine #(
        .NICKEL_VAL(NICKEL),
        .DIME_VAL  (DIME),
        .PRICE     (PRICE),
        .CW        (CW)
    ) dut (
        .coin  (coin),
        .rst   (rst),
        .ticket(ticket),
        .clk   (clk),
        .credit(credit),
        .reject(reject)
`ifdef VM_CHANGE_EN
        ,
        .change(change)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Apply one coin/reset for one edge, advance the model, compare outputs.
    task automatic step(input logic [1:0] c, input logic r);
        int v;
        int s;
        coin = c;
        rst  = r;
        @(posedge clk);
        #1;
        m_ticket = 0;
        m_reject = 0;
        m_change = 0;
        if (r) begin
            m_credit = 0;
        end else if (c == 2'b11) begin
            m_reject = 1;
        end else if (c != 2'b00) begin
            v = (c == 2'b01) ? NICKEL : DIME;
            s = m_credit + v;
            if (s >= PRICE) begin
                m_ticket = 1;
                m_change = s - PRICE;
                m_credit = 0;
            end else begin
                m_credit = s;
            end
        end
        if (ticket === 1'b1) n_tickets++;
        check("ticket", 32'(ticket), 32'(m_ticket));
        check("reject", 32'(reject), 32'(m_reject));
        check("credit", 32'(credit), 32'(m_credit));
`ifdef VM_CHANGE_EN
        check("change", 32'(change), 32'(m_change));
`endif
    endtask

    initial begin
        coin = 2'b00;
        rst  = 1'b1;

        // reset state, including a coin ignored during reset
        step(2'b00, 1'b1);
        step(2'b01, 1'b1);

        // three nickels
        step(2'b01, 1'b0);
        step(2'b01, 1'b0);
        step(2'b01, 1'b0);
        step(2'b00, 1'b0);

        // reset, then none, nickel, dime
        step(2'b00, 1'b1);
        step(2'b00, 1'b0);
        step(2'b01, 1'b0);
        step(2'b10, 1'b0);
        step(2'b00, 1'b0);

        // two dimes: overpay of 5
        step(2'b10, 1'b0);
        step(2'b10, 1'b0);
        step(2'b00, 1'b0);

        // invalid coin at credit 5
        step(2'b01, 1'b0);
        step(2'b11, 1'b0);
        step(2'b00, 1'b0);
        step(2'b10, 1'b0);

        // reset mid-accumulation with a coin present
        step(2'b10, 1'b0);
        step(2'b01, 1'b1);
        step(2'b01, 1'b0);
        step(2'b10, 1'b0);

        // back-to-back sales
        step(2'b10, 1'b0);
        step(2'b10, 1'b0);
        step(2'b10, 1'b0);
        step(2'b01, 1'b0);
        step(2'b00, 1'b0);

        // sustained 00,01,10 pattern gives three pulses
        n_tickets = 0;
        repeat (3) begin
            step(2'b00, 1'b0);
            step(2'b01, 1'b0);
            step(2'b10, 1'b0);
        end
        step(2'b00, 1'b0);
        check("pulses", 32'(n_tickets), 32'd3);

        // random coins with occasional reset
        repeat (400) begin
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
